alu_mem_unit: RTL and testbench
===============================

Name: alu_mem_unit

Overview:
- Execute/memory slice of the single-cycle MIPS datapath.
- Decodes the 2-bit main-control ALU op plus the instruction funct field into a 4-bit ALU control code and a jump-register flag.
- Performs the 32-bit ALU operation and produces the zero flag.
- Hosts the word-organised data memory, addressed by the ALU result.
- Sits between the register file / ALU-source mux and the write-back mux.

Parameters:
- DATA_W, 32, datapath width in bits.
- MEM_WORDS, 256, data memory depth in 32-bit words; power of two.

Ports:
- clk  input  1  rising-edge clock for memory writes.
- reset  input  1  asynchronous, active-low reset.
- alu_op  input  2  main-control ALU op: {aluop1, aluop0}.
- funct  input  6  instruction[5:0].
- shamt  input  5  instruction[10:6].
- operand_a  input  DATA_W  register read data 1.
- operand_b  input  DATA_W  ALU-source mux output.
- store_data  input  DATA_W  register read data 2; the memory write data.
- mem_read  input  1  memory read enable.
- mem_write  input  1  memory write enable.
- alu_ctrl  output  4  decoded ALU control code.
- jump_reg  output  1  high for jr; steers the PC-source mux.
- alu_result  output  DATA_W  ALU result; also the memory byte address.
- zero  output  1  high when alu_result == 0.
- read_data  output  DATA_W  memory read data.

Behaviour:
- Control decode is purely combinational.
  - alu_op 00 -> ADD (lw/sw).
  - alu_op 01 -> SUB (beq).
  - alu_op 11 -> OR (immediate logical).
  - alu_op 10 -> decode funct:
    - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 000000 SLL, 000010 SRL.
    - 001000 (jr) -> ADD with jump_reg=1.
    - Any other funct -> ADD, jump_reg=0.
  - jump_reg is 0 whenever alu_op != 10.
- ALU control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, SLL 1000, SRL 1001. An unused code yields result 0.
- ALU is combinational, with A = operand_a and B = operand_b.
  - ADD/SUB: modulo 2^32; no trap on overflow.
  - SLT: signed compare; result is 1 if A < B, else 0.
  - SLL/SRL: shift B by shamt; SRL is logical (zero fill). A is ignored.
  - zero is derived from the final result for every op.
- Data memory: MEM_WORDS x DATA_W array, word index = alu_result[log2(MEM_WORDS)+1:2].
  - Upper address bits are ignored, so accesses wrap modulo the memory size.
  - Low two address bits are ignored; all accesses are aligned words.
- Write: on rising clk, when reset is high and mem_write is 1, store_data is written to the indexed word.
- Read: combinational. read_data = word at index when mem_read=1, else 0.
- Read and write of the same word in the same cycle: read_data shows the old value until the edge, then the new value.
- mem_read and mem_write both high: the write happens and the read is still driven.
- Reset (reset=0):
  - Asynchronously clears every memory word to 0.
  - Writes are blocked while reset is low.
  - Reset asserted mid-write cancels that write.
  - Combinational outputs are unaffected by reset.
  - Memory is zero immediately after reset deasserts.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit).
  - overflow is high on ADD when the operands have the same sign and the result sign differs.
  - overflow is high on SUB when the operands have different signs and the result sign differs from A.
  - overflow is 0 for all other ops.
  - It is a flag only; the result is unchanged.
- Undefined: the port does not exist and no overflow logic is built.

Decomposition:
- Package alu_mem_pkg holds:
  - ALU control code constants.
  - alu_op encodings.
  - funct constants, including FUNCT_JR.
  - DATA_W default.
- One natural sub-module, alu_mem_dmem: the memory array with async clear, gated write and enable-gated combinational read.
- Decode and ALU stay in the top as combinational blocks.

Test Plan:
- Decode sweep:
  - alu_op=10 with funct 100000/100010/100100/100101/100111/101010/000000/000010 -> alu_ctrl 0010/0110/0000/0001/1100/0111/1000/1001, jump_reg=0.
  - funct 001000 -> alu_ctrl 0010, jump_reg=1.
  - alu_op=00 -> 0010; 01 -> 0110; 11 -> 0001.
- Arithmetic:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, zero=0.
  - SUB 5-5 -> 0, zero=1.
  - SLT 0xFFFFFFFF vs 1 -> 1.
  - NOR 0,0 -> 0xFFFFFFFF.
- Shifts:
  - SLL B=0x00000001, shamt=31 -> 0x80000000.
  - SRL B=0x80000000, shamt=4 -> 0x08000000; A=0xDEADBEEF has no effect.
- Memory store/load:
  - sw 0xCAFEF00D at address 0x10 (alu_op=00, A=0x0C, B=4).
  - Next cycle, mem_read=1 -> read_data=0xCAFEF00D.
  - mem_read=0 -> read_data=0.
  - Address 0x10+4*MEM_WORDS reads the same word (wrap).
- Reset: write 0x12345678 to word 3, pulse reset low asynchronously between edges -> word 3 reads 0. A mem_write asserted during reset low is not stored.
- Same-cycle read/write: word 5 holds 0xAAAA, write 0x5555 with mem_read=1 -> read_data 0xAAAA before the edge, 0x5555 after.

Source files
------------

// File: rtl/alu_mem_pkg.sv
// Shared encodings for the MIPS execute/memory slice: ALU ops, ALU control codes, funct values.
// Optional overflow flag is built when ALU_OVERFLOW_EN is defined.
package alu_mem_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MEM_WORDS = 256;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;
    localparam logic [5:0] FUNCT_JR  = 6'b001000;

    typedef struct packed {
        alu_ctrl_e ctrl;
        logic      jump_reg;
    } alu_dec_t;

endpackage

// File: rtl/alu_mem_if.sv
// Datapath-side bundle of the execute/memory slice; master drives operands, slave returns results.
// The overflow wire exists only when ALU_OVERFLOW_EN is defined.
interface alu_mem_if
    import alu_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] store_data;
    logic              mem_read;
    logic              mem_write;
    logic [3:0]        alu_ctrl;
    logic              jump_reg;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [DATA_W-1:0] read_data;
`ifdef ALU_OVERFLOW_EN
    logic              overflow;
`endif

    modport master (
        output alu_op, funct, shamt, operand_a, operand_b, store_data, mem_read, mem_write,
        input  alu_ctrl, jump_reg, alu_result, zero, read_data
`ifdef ALU_OVERFLOW_EN
        , input overflow
`endif
    );

    modport slave (
        input  alu_op, funct, shamt, operand_a, operand_b, store_data, mem_read, mem_write,
        output alu_ctrl, jump_reg, alu_result, zero, read_data
`ifdef ALU_OVERFLOW_EN
        , output overflow
`endif
    );

endinterface

// File: rtl/alu_mem_dmem.sv
// Word-organised data memory: async clear on reset, write on rising clk, enable-gated combinational read.
module alu_mem_dmem
    import alu_mem_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_WORDS = DEF_MEM_WORDS,
    localparam int AW       = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [MEM_WORDS];

    // Reset wins over a pending write, so a write overlapping reset is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = re ? mem[addr] : '0;

endmodule

// File: rtl/alu_mem_unit.sv
// Execute/memory slice of the single-cycle MIPS datapath: ALU control decode, 32-bit ALU, data memory.
// Define ALU_OVERFLOW_EN to add the signed-overflow flag for ADD/SUB.
module alu_mem_unit
    import alu_mem_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_WORDS = DEF_MEM_WORDS
) (
    input logic       clk,
    input logic       reset,
    alu_mem_if.slave  bus
);
    localparam int AW = $clog2(MEM_WORDS);

    alu_dec_t          dec;
    logic [DATA_W-1:0] a, b, result;
    logic              unused_addr_bits;

    assign a = bus.operand_a;
    assign b = bus.operand_b;

    always_comb begin
        dec.ctrl     = ALU_ADD;
        dec.jump_reg = 1'b0;
        case (alu_op_e'(bus.alu_op))
            ALUOP_ADD: dec.ctrl = ALU_ADD;
            ALUOP_SUB: dec.ctrl = ALU_SUB;
            ALUOP_OR:  dec.ctrl = ALU_OR;
            ALUOP_FUNCT: begin
                case (bus.funct)
                    FUNCT_ADD: dec.ctrl = ALU_ADD;
                    FUNCT_SUB: dec.ctrl = ALU_SUB;
                    FUNCT_AND: dec.ctrl = ALU_AND;
                    FUNCT_OR:  dec.ctrl = ALU_OR;
                    FUNCT_NOR: dec.ctrl = ALU_NOR;
                    FUNCT_SLT: dec.ctrl = ALU_SLT;
                    FUNCT_SLL: dec.ctrl = ALU_SLL;
                    FUNCT_SRL: dec.ctrl = ALU_SRL;
                    // jr reuses the adder so the register value passes through untouched
                    FUNCT_JR: begin
                        dec.ctrl     = ALU_ADD;
                        dec.jump_reg = 1'b1;
                    end
                    default:   dec.ctrl = ALU_ADD;
                endcase
            end
            default: dec.ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        result = '0;
        case (dec.ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_NOR: result = ~(a | b);
            ALU_SLL: result = b << bus.shamt;
            ALU_SRL: result = b >> bus.shamt;
            default: result = '0;
        endcase
    end

    assign bus.alu_ctrl   = dec.ctrl;
    assign bus.jump_reg   = dec.jump_reg;
    assign bus.alu_result = result;
    assign bus.zero       = (result == '0);

`ifdef ALU_OVERFLOW_EN
    logic ov;
    always_comb begin
        ov = 1'b0;
        case (dec.ctrl)
            ALU_ADD: ov = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            ALU_SUB: ov = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            default: ov = 1'b0;
        endcase
    end
    assign bus.overflow = ov;
`endif

    // Byte address: low two bits and bits above the memory size are dropped (aligned, wrapping).
    assign unused_addr_bits = ^{result[DATA_W-1:AW+2], result[1:0]};

    alu_mem_dmem #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS)
    ) u_dmem (
        .clk   (clk),
        .reset (reset),
        .addr  (result[AW+1:2]),
        .wdata (bus.store_data),
        .we    (bus.mem_write),
        .re    (bus.mem_read),
        .rdata (bus.read_data)
    );

endmodule

// File: tb/tb_alu_mem_unit.sv
// Self-checking bench for alu_mem_unit: directed corner cases plus randomized ops and memory traffic.
module tb_alu_mem_unit;
    localparam int MW = 256;
    localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_NOR = 4,
                   OP_SLT = 5, OP_SLL = 6, OP_SRL = 7;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] mdl [MW];

    always #5 clk = ~clk;

    alu_mem_if #(.DATA_W(32)) bus ();

    alu_mem_unit #(.DATA_W(32), .MEM_WORDS(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model: the operation a MIPS instruction names, then what that operation computes.
    function automatic int ref_op(input logic [1:0] aop, input logic [5:0] f, output logic jr);
        jr = 1'b0;
        if (aop == 2'b00) return OP_ADD;
        if (aop == 2'b01) return OP_SUB;
        if (aop == 2'b11) return OP_OR;
        case (f)
            6'h20: return OP_ADD;
            6'h22: return OP_SUB;
            6'h24: return OP_AND;
            6'h25: return OP_OR;
            6'h27: return OP_NOR;
            6'h2A: return OP_SLT;
            6'h00: return OP_SLL;
            6'h02: return OP_SRL;
            6'h08: begin jr = 1'b1; return OP_ADD; end
            default: return OP_ADD;
        endcase
    endfunction

    function automatic logic [3:0] ref_code(input int op);
        case (op)
            OP_AND: return 4'b0000;
            OP_OR:  return 4'b0001;
            OP_ADD: return 4'b0010;
            OP_SUB: return 4'b0110;
            OP_SLT: return 4'b0111;
            OP_NOR: return 4'b1100;
            OP_SLL: return 4'b1000;
            default: return 4'b1001;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b,
                                            input int sh);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_ADD: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            OP_SUB: return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_NOR: return ~(a | b);
            OP_SLT: return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLL: return 32'((longint'(b) * (64'd1 << sh)) % 64'h1_0000_0000);
            default: return 32'(longint'(b) / (64'd1 << sh));
        endcase
    endfunction

    function automatic logic ref_ovf(input int op, input logic [31:0] a, input logic [31:0] b);
        longint s;
        if (op == OP_ADD)      s = longint'($signed(a)) + longint'($signed(b));
        else if (op == OP_SUB) s = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 4) % MW);
    endfunction

    task automatic drive(input logic [1:0] aop, input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
        bus.alu_op = aop; bus.funct = f; bus.shamt = sh;
        bus.operand_a = a; bus.operand_b = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.store_data = '0;
        drive(2'b00, 6'h00, 5'd0, 32'd3, 32'd4);
        reset = 1'b1;
        #3 reset = 1'b0;
        #2;
        n_cmp++;
        if (bus.alu_result !== 32'd7) begin
            n_err++; $display("FAIL reset_comb: got %h expected %h", bus.alu_result, 32'd7);
        end
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < MW; i++) mdl[i] = '0;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] addr;
            addr = $urandom;
            drive(2'b00, 6'h00, 5'd0, addr, 32'd0);
            bus.mem_read = 1'b1;
            #1;
            n_cmp++;
            if (bus.read_data !== 32'd0) begin
                n_err++; $display("FAIL reset_mem_zero: addr %h got %h expected 0", addr, bus.read_data);
            end
        end
        bus.mem_read = 1'b0;
    endtask

    task automatic test_decode();
        logic [5:0] f_tab [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                                  6'b101010, 6'b000000, 6'b000010, 6'b001000};
        logic [3:0] c_tab [9] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100,
                                  4'b0111, 4'b1000, 4'b1001, 4'b0010};
        logic [1:0] op_tab [3] = '{2'b00, 2'b01, 2'b11};
        logic [3:0] oc_tab [3] = '{4'b0010, 4'b0110, 4'b0001};
        for (int i = 0; i < 9; i++) begin
            drive(2'b10, f_tab[i], 5'd0, 32'd1, 32'd2);
            #1;
            n_cmp++;
            if (bus.alu_ctrl !== c_tab[i] || bus.jump_reg !== (i == 8)) begin
                n_err++;
                $display("FAIL decode_funct %b: got ctrl %b jr %b expected ctrl %b jr %b",
                         f_tab[i], bus.alu_ctrl, bus.jump_reg, c_tab[i], (i == 8));
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(op_tab[i], 6'b001000, 5'd0, 32'd1, 32'd2);
            #1;
            n_cmp++;
            if (bus.alu_ctrl !== oc_tab[i] || bus.jump_reg !== 1'b0) begin
                n_err++;
                $display("FAIL decode_aluop %b: got ctrl %b jr %b expected ctrl %b jr 0",
                         op_tab[i], bus.alu_ctrl, bus.jump_reg, oc_tab[i]);
            end
        end
    endtask

    task automatic test_arith();
        logic [5:0]  f [6]   = '{6'h20, 6'h22, 6'h2A, 6'h27, 6'h00, 6'h02};
        logic [4:0]  sh [6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd4};
        logic [31:0] a [6]   = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd0, 32'h0, 32'hDEADBEEF};
        logic [31:0] b [6]   = '{32'd1, 32'd5, 32'd1, 32'd0, 32'd1, 32'h80000000};
        logic [31:0] exp [6] = '{32'h80000000, 32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h08000000};
        for (int i = 0; i < 6; i++) begin
            drive(2'b10, f[i], sh[i], a[i], b[i]);
            #1;
            n_cmp++;
            if (bus.alu_result !== exp[i] || bus.zero !== (exp[i] == 32'd0)) begin
                n_err++;
                $display("FAIL arith_%0d: got %h zero %b expected %h zero %b",
                         i, bus.alu_result, bus.zero, exp[i], (exp[i] == 32'd0));
            end
        end
    endtask

    task automatic test_alu_random();
        logic [5:0]  fl [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h08, 6'h3F};
        logic [31:0] corner [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        for (int i = 0; i < 300; i++) begin
            logic [1:0]  aop;
            logic [5:0]  f;
            logic [4:0]  sh;
            logic [31:0] a, b, exp_r;
            logic        jr;
            int          op;
            aop = 2'($urandom);
            f   = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fl[$urandom_range(0, 9)];
            sh  = 5'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            drive(aop, f, sh, a, b);
            #1;
            op    = ref_op(aop, f, jr);
            exp_r = ref_alu(op, a, b, int'(sh));
            n_cmp++;
            if (bus.alu_ctrl !== ref_code(op) || bus.jump_reg !== jr) begin
                n_err++;
                $display("FAIL rnd_decode op=%b f=%b: got %b/%b expected %b/%b",
                         aop, f, bus.alu_ctrl, bus.jump_reg, ref_code(op), jr);
            end
            n_cmp++;
            if (bus.alu_result !== exp_r || bus.zero !== (exp_r == 0)) begin
                n_err++;
                $display("FAIL rnd_alu op=%b f=%b a=%h b=%h sh=%0d: got %h/%b expected %h/%b",
                         aop, f, a, b, sh, bus.alu_result, bus.zero, exp_r, (exp_r == 0));
            end
`ifdef ALU_OVERFLOW_EN
            n_cmp++;
            if (bus.overflow !== ref_ovf(op, a, b)) begin
                n_err++;
                $display("FAIL rnd_ovf a=%h b=%h op=%0d: got %b expected %b",
                         a, b, op, bus.overflow, ref_ovf(op, a, b));
            end
`endif
        end
    endtask

    task automatic test_mem();
        bus.store_data = 32'hCAFEF00D; bus.mem_write = 1'b1; bus.mem_read = 1'b0;
        drive(2'b00, 6'h00, 5'd0, 32'h0C, 32'd4);
        #1;
        n_cmp++;
        if (bus.alu_result !== 32'h10) begin
            n_err++; $display("FAIL sw_addr: got %h expected %h", bus.alu_result, 32'h10);
        end
        step();
        mdl[4] = 32'hCAFEF00D;
        bus.mem_write = 1'b0; bus.mem_read = 1'b1;
        #1;
        n_cmp++;
        if (bus.read_data !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL lw: got %h expected %h", bus.read_data, 32'hCAFEF00D);
        end
        bus.mem_read = 1'b0;
        #1;
        n_cmp++;
        if (bus.read_data !== 32'd0) begin
            n_err++; $display("FAIL lw_disabled: got %h expected 0", bus.read_data);
        end
        bus.mem_read = 1'b1;
        drive(2'b00, 6'h00, 5'd0, 32'h10 + 4 * MW, 32'd0);
        #1;
        n_cmp++;
        if (bus.read_data !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL lw_wrap: got %h expected %h", bus.read_data, 32'hCAFEF00D);
        end
        bus.mem_read = 1'b0;
    endtask

    task automatic test_same_cycle();
        step();
        drive(2'b00, 6'h00, 5'd0, 32'h14, 32'd0);
        bus.store_data = 32'h0000AAAA; bus.mem_write = 1'b1; bus.mem_read = 1'b0;
        step();
        mdl[5] = 32'h0000AAAA;
        bus.store_data = 32'h00005555; bus.mem_read = 1'b1;
        #1;
        n_cmp++;
        if (bus.read_data !== 32'h0000AAAA) begin
            n_err++; $display("FAIL rw_before_edge: got %h expected %h", bus.read_data, 32'h0000AAAA);
        end
        step();
        mdl[5] = 32'h00005555;
        n_cmp++;
        if (bus.read_data !== 32'h00005555) begin
            n_err++; $display("FAIL rw_after_edge: got %h expected %h", bus.read_data, 32'h00005555);
        end
        bus.mem_write = 1'b0; bus.mem_read = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(2'b00, 6'h00, 5'd0, 32'h0C, 32'd0);
        bus.store_data = 32'h12345678; bus.mem_write = 1'b1;
        step();
        bus.mem_write = 1'b0; bus.mem_read = 1'b1;
        #1;
        n_cmp++;
        if (bus.read_data !== 32'h12345678) begin
            n_err++; $display("FAIL pre_reset_word3: got %h expected %h", bus.read_data, 32'h12345678);
        end
        #1 reset = 1'b0;
        for (int i = 0; i < MW; i++) mdl[i] = '0;
        #1;
        n_cmp++;
        if (bus.read_data !== 32'd0) begin
            n_err++; $display("FAIL async_clear_word3: got %h expected 0", bus.read_data);
        end
        // A write held across a clock edge while reset is low must be lost.
        drive(2'b00, 6'h00, 5'd0, 32'h20, 32'd0);
        bus.store_data = 32'hDEADDEAD; bus.mem_write = 1'b1;
        step();
        bus.mem_write = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.read_data !== 32'd0) begin
            n_err++; $display("FAIL write_during_reset: got %h expected 0", bus.read_data);
        end
        bus.mem_read = 1'b0;
    endtask

    task automatic test_mem_random();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b, exp_rd;
            logic        we, re;
            int          w;
            step();
            a  = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            b  = 32'($urandom_range(0, 3)) << 2;
            we = $urandom_range(0, 2) == 0;
            re = $urandom_range(0, 3) != 0;
            drive(2'b00, 6'h00, 5'd0, a, b);
            bus.store_data = $urandom; bus.mem_write = we; bus.mem_read = re;
            #1;
            w      = word_of(a + b);
            exp_rd = re ? mdl[w] : 32'd0;
            n_cmp++;
            if (bus.read_data !== exp_rd) begin
                n_err++;
                $display("FAIL rnd_mem addr=%h re=%b: got %h expected %h", a + b, re, bus.read_data, exp_rd);
            end
            if (we) mdl[w] = bus.store_data;
        end
        step();
        bus.mem_write = 1'b0; bus.mem_read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_arith();
        test_alu_random();
        test_mem();
        test_same_cycle();
        test_reset_mid();
        test_mem_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
